// File: rtl/int32_stream_formatter_pkg.sv
// Shared ASCII constants, decimal power table and formatter state encoding
// for the int32 -> ASCII decimal stream formatter.
package int32_stream_formatter_pkg;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  localparam logic [31:0] POW10 [0:9] = '{
    32'd1, 32'd10, 32'd100, 32'd1000, 32'd10000,
    32'd100000, 32'd1000000, 32'd10000000, 32'd100000000, 32'd1000000000
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEP,
    ST_SIGN,
    ST_CALC,
    ST_EMIT,
    ST_TERM
  } state_t;

  // Constant-index lookup keeps the table access free of out-of-range indices.
  function automatic logic [31:0] pow10(input logic [3:0] idx);
    logic [31:0] p;
    p = '0;
    case (idx)
      4'd0: p = POW10[0];
      4'd1: p = POW10[1];
      4'd2: p = POW10[2];
      4'd3: p = POW10[3];
      4'd4: p = POW10[4];
      4'd5: p = POW10[5];
      4'd6: p = POW10[6];
      4'd7: p = POW10[7];
      4'd8: p = POW10[8];
      4'd9: p = POW10[9];
      default: p = '0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/int32_stream_formatter_if.sv
// Number-in / character-out handshake bundle of the stream formatter.
interface int32_stream_formatter_if;
  logic        num_valid;
  logic [31:0] num_data;
  logic        num_last;
  logic        num_ready;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_last;
  logic        char_ready;

  modport master (
    output num_valid, num_data, num_last, char_ready,
    input  num_ready, char_valid, char_data, char_last
  );

  modport slave (
    input  num_valid, num_data, num_last, char_ready,
    output num_ready, char_valid, char_data, char_last
  );
endinterface

// File: rtl/int32_digit_extractor.sv
// Repeated-subtraction decimal digit extractor: produces the digits of a
// 32-bit magnitude most-significant first, suppressing leading zeros.
module int32_digit_extractor
  import int32_stream_formatter_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] mag_in,
  input  logic        next,
  output logic        digit_ready,
  output logic [3:0]  digit,
  output logic        digit_final
);

  logic [31:0] mag_reg;
  logic [3:0]  idx_reg;
  logic [3:0]  digit_reg;
  logic        started_reg;
  logic        active_reg;
  logic [31:0] pow_cur;
  logic        ge;
  logic        skip;

  always_comb begin
    pow_cur = pow10(idx_reg);
    ge      = (mag_reg >= pow_cur);
    // Position 0 is never skipped, so a zero magnitude still yields "0".
    skip    = (digit_reg == 4'd0) && !started_reg && (idx_reg != 4'd0);
  end

  assign digit_ready = active_reg && !ge && !skip;
  assign digit       = digit_reg;
  assign digit_final = (idx_reg == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_reg     <= '0;
      idx_reg     <= '0;
      digit_reg   <= '0;
      started_reg <= 1'b0;
      active_reg  <= 1'b0;
    end else if (start) begin
      mag_reg     <= mag_in;
      idx_reg     <= 4'd9;
      digit_reg   <= '0;
      started_reg <= 1'b0;
      active_reg  <= 1'b1;
    end else if (active_reg) begin
      if (next && digit_ready) begin
        started_reg <= 1'b1;
        digit_reg   <= '0;
        if (idx_reg == 4'd0) begin
          active_reg <= 1'b0;
        end else begin
          idx_reg <= idx_reg - 4'd1;
        end
      end else if (ge) begin
        mag_reg   <= mag_reg - pow_cur;
        digit_reg <= digit_reg + 4'd1;
      end else if (skip) begin
        idx_reg <= idx_reg - 4'd1;
      end
    end
  end

endmodule

// File: rtl/int32_stream_formatter.sv
// Signed 32-bit integer stream to ASCII decimal byte stream: separators,
// optional line wrapping and frame termination around the digit extractor.
module int32_stream_formatter
  import int32_stream_formatter_pkg::*;
#(
  parameter logic [7:0] SEP_CHAR      = ASCII_SPACE,
  parameter logic [7:0] EOL_CHAR      = ASCII_LF,
  parameter int         NUMS_PER_LINE = 0,
  parameter bit         TERM_EN       = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  int32_stream_formatter_if.slave        bus,
  output logic [10:0]                    num_count,
  output logic                           busy
);

  localparam int             LW       = (NUMS_PER_LINE == 0) ? 1 : $clog2(NUMS_PER_LINE + 1);
  localparam logic [LW-1:0]  LINE_MAX = LW'(NUMS_PER_LINE);
  localparam bit             WRAP_EN  = (NUMS_PER_LINE != 0);

  state_t        state_reg;
  logic          num_ready_reg;
  logic          char_valid_reg;
  logic [7:0]    char_data_reg;
  logic          char_last_reg;
  logic [10:0]   num_count_reg;
  logic [LW-1:0] line_cnt_reg;
  logic          first_reg;
  logic          neg_reg;
  logic          last_reg;

  logic          accept;
  logic          char_xfer;
  logic          neg_in;
  logic [31:0]   mag_in;
  logic          wrap_now;
  logic          x_next;
  logic          x_ready;
  logic [3:0]    x_digit;
  logic          x_final;

  assign accept    = (state_reg == ST_IDLE) && bus.num_valid && num_ready_reg;
  assign char_xfer = char_valid_reg && bus.char_ready;
  assign neg_in    = bus.num_data[31];
  // Two's-complement negate; -2^31 maps to the unsigned value 2^31.
  assign mag_in    = neg_in ? (~bus.num_data + 32'd1) : bus.num_data;
  assign wrap_now  = WRAP_EN && (line_cnt_reg == LINE_MAX);
  assign x_next    = (state_reg == ST_EMIT) && char_xfer;

  int32_digit_extractor u_digits (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (accept),
    .mag_in      (mag_in),
    .next        (x_next),
    .digit_ready (x_ready),
    .digit       (x_digit),
    .digit_final (x_final)
  );

  assign bus.num_ready  = num_ready_reg;
  assign bus.char_valid = char_valid_reg;
  assign bus.char_data  = char_data_reg;
  assign bus.char_last  = char_last_reg;
  assign num_count      = num_count_reg;
  assign busy           = (state_reg != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      num_ready_reg  <= 1'b0;
      char_valid_reg <= 1'b0;
      char_data_reg  <= '0;
      char_last_reg  <= 1'b0;
      num_count_reg  <= '0;
      line_cnt_reg   <= '0;
      first_reg      <= 1'b1;
      neg_reg        <= 1'b0;
      last_reg       <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            num_ready_reg <= 1'b0;
            neg_reg       <= neg_in;
            last_reg      <= bus.num_last;
            char_last_reg <= 1'b0;
            if (first_reg) begin
              num_count_reg <= '0;
            end
            if (!first_reg) begin
              state_reg      <= ST_SEP;
              char_valid_reg <= 1'b1;
              if (wrap_now) begin
                char_data_reg <= EOL_CHAR;
                line_cnt_reg  <= '0;
              end else begin
                char_data_reg <= SEP_CHAR;
              end
            end else if (neg_in) begin
              state_reg      <= ST_SIGN;
              char_valid_reg <= 1'b1;
              char_data_reg  <= ASCII_MINUS;
            end else begin
              state_reg <= ST_CALC;
            end
          end else begin
            num_ready_reg <= 1'b1;
          end
        end

        ST_SEP: begin
          if (char_xfer) begin
            if (neg_reg) begin
              state_reg     <= ST_SIGN;
              char_data_reg <= ASCII_MINUS;
            end else begin
              state_reg      <= ST_CALC;
              char_valid_reg <= 1'b0;
            end
          end
        end

        ST_SIGN: begin
          if (char_xfer) begin
            state_reg      <= ST_CALC;
            char_valid_reg <= 1'b0;
          end
        end

        ST_CALC: begin
          if (x_ready) begin
            state_reg      <= ST_EMIT;
            char_valid_reg <= 1'b1;
            char_data_reg  <= ASCII_ZERO + {4'd0, x_digit};
            char_last_reg  <= !TERM_EN && last_reg && x_final;
          end
        end

        ST_EMIT: begin
          if (char_xfer) begin
            char_valid_reg <= 1'b0;
            char_last_reg  <= 1'b0;
            if (!x_final) begin
              state_reg <= ST_CALC;
            end else begin
              if (num_count_reg != 11'h7FF) begin
                num_count_reg <= num_count_reg + 11'd1;
              end
              first_reg <= 1'b0;
              if (last_reg) begin
                line_cnt_reg <= '0;
                if (TERM_EN) begin
                  state_reg      <= ST_TERM;
                  char_valid_reg <= 1'b1;
                  char_data_reg  <= EOL_CHAR;
                  char_last_reg  <= 1'b1;
                end else begin
                  state_reg     <= ST_IDLE;
                  first_reg     <= 1'b1;
                  num_ready_reg <= 1'b1;
                end
              end else begin
                if (WRAP_EN) begin
                  line_cnt_reg <= line_cnt_reg + LW'(1);
                end
                state_reg     <= ST_IDLE;
                num_ready_reg <= 1'b1;
              end
            end
          end
        end

        ST_TERM: begin
          if (char_xfer) begin
            state_reg      <= ST_IDLE;
            char_valid_reg <= 1'b0;
            char_last_reg  <= 1'b0;
            first_reg      <= 1'b1;
            line_cnt_reg   <= '0;
            num_ready_reg  <= 1'b1;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int32_stream_formatter.sv
// Randomised self-checking bench: two formatter instances (no wrap / wrap every 2)
// checked byte-by-byte against a string-based decimal formatting model.
module tb_int32_stream_formatter;
  import int32_stream_formatter_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int32_stream_formatter_if bus0 ();
  int32_stream_formatter_if bus1 ();
  logic [10:0] cnt0;
  logic [10:0] cnt1;
  logic        busy0;
  logic        busy1;

  int32_stream_formatter dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus0),
    .num_count (cnt0),
    .busy      (busy0)
  );

  int32_stream_formatter #(.NUMS_PER_LINE(2)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus1),
    .num_count (cnt1),
    .busy      (busy1)
  );

  int          passed = 0;
  int          total = 0;
  logic [7:0]  exp_d [2][$];
  bit          exp_l [2][$];
  string       cap [2];
  bit          stall [2];
  logic [7:0]  hold_d [2];
  logic        hold_l [2];
  bit          rnd_ready = 1'b0;
  int          frame_idx = 0;
  int          frame_len = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic string hexs(input string s);
    string r = "";
    for (int i = 0; i < s.len(); i++) r = {r, $sformatf("%02h ", s[i])};
    return r;
  endfunction

  task automatic chk_str(input string name, input string act, input string exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got [%s] expected [%s]", name, hexs(act), hexs(exp));
  endtask

  // Reference: k-th number of a frame, decimal text via $sformatf, wrap every npl numbers.
  function automatic string fmt_num(input int k, input logic [31:0] v, input bit last, input int npl);
    string s = "";
    if (k > 0) s = (npl != 0 && (k % npl) == 0) ? "\n" : " ";
    s = {s, $sformatf("%0d", $signed(v))};
    if (last) s = {s, "\n"};
    return s;
  endfunction

  task automatic model_push(input logic [31:0] v, input bit last);
    for (int w = 0; w < 2; w++) begin
      string s;
      s = fmt_num(frame_idx, v, last, (w == 0) ? 0 : 2);
      for (int i = 0; i < s.len(); i++) begin
        exp_d[w].push_back(s[i]);
        exp_l[w].push_back(last && (i == s.len() - 1));
      end
    end
    if (last) begin
      frame_len = frame_idx + 1;
      frame_idx = 0;
    end else begin
      frame_idx++;
    end
  endtask

  task automatic mon(input int w, input logic v, input logic r, input logic [7:0] d, input logic l);
    logic [7:0] ed;
    bit el;
    if (!rst_n) begin
      stall[w] = 1'b0;
      return;
    end
    if (stall[w]) begin
      chk($sformatf("hold_valid%0d", w), {31'd0, v}, 32'd1);
      chk($sformatf("hold_byte%0d", w), {23'd0, l, d}, {23'd0, hold_l[w], hold_d[w]});
    end
    if (v && r) begin
      if (exp_d[w].size() == 0) begin
        total++;
        $display("FAIL extra_byte%0d: got %02h expected no byte", w, d);
      end else begin
        ed = exp_d[w].pop_front();
        el = exp_l[w].pop_front();
        chk($sformatf("byte%0d", w), {24'd0, d}, {24'd0, ed});
        chk($sformatf("last%0d", w), {31'd0, l}, {31'd0, el});
      end
      cap[w] = {cap[w], $sformatf("%c", d)};
    end
    stall[w]  = v && !r;
    hold_d[w] = d;
    hold_l[w] = l;
  endtask

  initial forever begin
    @(negedge clk);
    mon(0, bus0.char_valid, bus0.char_ready, bus0.char_data, bus0.char_last);
    mon(1, bus1.char_valid, bus1.char_ready, bus1.char_data, bus1.char_last);
  end

  initial forever begin
    @(posedge clk);
    #1;
    bus0.char_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    bus1.char_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic send(input logic [31:0] v, input bit last);
    bit done0 = 1'b0;
    bit done1 = 1'b0;
    bit a0;
    bit a1;
    int t = 0;
    model_push(v, last);
    @(posedge clk);
    #1;
    bus0.num_data = v; bus0.num_last = last; bus0.num_valid = 1'b1;
    bus1.num_data = v; bus1.num_last = last; bus1.num_valid = 1'b1;
    while (!(done0 && done1)) begin
      @(negedge clk);
      a0 = bus0.num_valid && bus0.num_ready;
      a1 = bus1.num_valid && bus1.num_ready;
      @(posedge clk);
      #1;
      if (a0) begin done0 = 1'b1; bus0.num_valid = 1'b0; end
      if (a1) begin done1 = 1'b1; bus1.num_valid = 1'b0; end
      t++;
      if (t > 5000) begin
        total++;
        $display("FAIL accept_timeout: got no accept expected accept of %0h", v);
        bus0.num_valid = 1'b0;
        bus1.num_valid = 1'b0;
        break;
      end
    end
  endtask

  task automatic end_frame();
    int t = 0;
    do begin
      @(negedge clk);
      #1;
      t++;
    end while ((exp_d[0].size() != 0 || exp_d[1].size() != 0 || busy0 || busy1) && t < 20000);
    if (t >= 20000) begin
      total++;
      $display("FAIL drain_timeout: got %0d/%0d bytes left expected 0", exp_d[0].size(), exp_d[1].size());
    end
    chk("num_count0", {21'd0, cnt0}, frame_len);
    chk("num_count1", {21'd0, cnt1}, frame_len);
  endtask

  task automatic clear_cap();
    cap[0] = "";
    cap[1] = "";
  endtask

  initial begin
    #900000;
    total++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    logic [31:0] v;
    bit last;
    int sel;
    int t;
    bus0.num_valid = 1'b0; bus0.num_data = '0; bus0.num_last = 1'b0; bus0.char_ready = 1'b1;
    bus1.num_valid = 1'b0; bus1.num_data = '0; bus1.num_last = 1'b0; bus1.char_ready = 1'b1;
    clear_cap();
    repeat (3) @(negedge clk);
    chk("rst_char_valid", {31'd0, bus0.char_valid}, 32'd0);
    chk("rst_char_data", {24'd0, bus0.char_data}, 32'd0);
    chk("rst_char_last", {31'd0, bus0.char_last}, 32'd0);
    chk("rst_num_count", {21'd0, cnt0}, 32'd0);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_num_ready", {31'd0, bus0.num_ready}, 32'd0);
    chk("rst_num_ready1", {31'd0, bus1.num_ready}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("ready_after_reset", {31'd0, bus0.num_ready}, 32'd1);

    chk_str("model_pin_neg", fmt_num(1, -45, 1'b0, 0), " -45");
    chk_str("model_pin_wrap", fmt_num(2, 3, 1'b1, 2), "\n3\n");

    clear_cap();
    send(0, 1'b1);
    end_frame();
    chk_str("zero", cap[0], "0\n");

    clear_cap();
    send(123, 1'b0); send(-45, 1'b0); send(7, 1'b1);
    end_frame();
    chk_str("frame_123", cap[0], "123 -45 7\n");

    clear_cap();
    send(32'd2147483647, 1'b0); send(32'h80000000, 1'b1);
    end_frame();
    chk_str("extremes", cap[0], "2147483647 -2147483648\n");

    clear_cap();
    for (int i = 1; i <= 6; i++) send(i, i == 6);
    end_frame();
    chk_str("wrap2", cap[1], "1 2\n3 4\n5 6\n");
    chk_str("nowrap", cap[0], "1 2 3 4 5 6\n");

    rnd_ready = 1'b1;
    clear_cap();
    send(123, 1'b0); send(-45, 1'b0); send(7, 1'b1);
    end_frame();
    chk_str("stall_frame0", cap[0], "123 -45 7\n");
    chk_str("stall_frame1", cap[1], "123 -45\n7\n");

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 3);
      if (sel == 0) v = $urandom_range(0, 9);
      else if (sel == 1) v = $urandom_range(0, 99999);
      else if (sel == 2) v = -$urandom_range(0, 99999);
      else v = $urandom;
      last = (i == 39) || ($urandom_range(0, 4) == 0);
      send(v, last);
      if (last) end_frame();
    end

    rnd_ready = 1'b0;
    clear_cap();
    send(98765, 1'b1);
    t = 0;
    while (cap[0].len() < 2 && t < 500) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("mid_digit_reached", {31'd0, cap[0].len() >= 2}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_char_valid", {31'd0, bus0.char_valid}, 32'd0);
    chk("abort_num_count", {21'd0, cnt0}, 32'd0);
    chk("abort_busy", {31'd0, busy0}, 32'd0);
    chk("abort_char_valid1", {31'd0, bus1.char_valid}, 32'd0);
    for (int w = 0; w < 2; w++) begin
      exp_d[w].delete();
      exp_l[w].delete();
    end
    frame_idx = 0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    clear_cap();
    send(5, 1'b1);
    end_frame();
    chk_str("after_abort0", cap[0], "5\n");
    chk_str("after_abort1", cap[1], "5\n");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
